// File: rtl/serial_subtractor8.sv
// -----------------------------------------------------------------------------
// serial_subtractor8
//
// Bit-serial unsigned subtractor. It computes diff = a - b, LSB first, one bit
// per clock, using a single full-subtractor cell and shift registers.
//
// Parameters:
//   WIDTH   operand/result width in bits (>= 2), default 8
//
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   asynchronous reset, active high
//   start   in   request; accepted only in IDLE or DONE
//   a       in   minuend, captured on an accepted start
//   b       in   subtrahend, captured on an accepted start
//   busy    out  high while the operation is shifting
//   done    out  one-cycle pulse when a new result has been loaded
//   diff    out  a - b mod 2^WIDTH, held until the next completion
//   borrow  out  1 when a < b (unsigned), held like diff
//   ovf     out  two's-complement overflow of a - b (SUB_OVERFLOW_EN only)
//
// Optional feature macro: SUB_OVERFLOW_EN
//   Defined     -> ovf reports signed overflow and is held like diff.
//   Not defined -> ovf is tied to 0 and no extra flops are built.
// -----------------------------------------------------------------------------
module serial_subtractor8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rega_q, rega_d;
    logic [WIDTH-1:0] regb_q, regb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             br_q, br_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             bit_d;
    logic             br_next;
    logic             accept;
    logic             last_cycle;

    // Full-subtractor cell working on the current LSBs.
    assign bit_d   = rega_q[0] ^ regb_q[0] ^ br_q;
    assign br_next = (~rega_q[0] & regb_q[0]) | (~(rega_q[0] ^ regb_q[0]) & br_q);

    // A start is honoured only when no operation is in flight.
    assign accept     = start && ((state_q == IDLE) || (state_q == DONE));
    assign last_cycle = (state_q == SHIFT) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d  = state_q;
        rega_d   = rega_q;
        regb_d   = regb_q;
        res_d    = res_q;
        diff_d   = diff_q;
        br_d     = br_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;

        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    rega_d  = a;
                    regb_d  = b;
                    res_d   = '0;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                res_d  = {bit_d, res_q[WIDTH-1:1]};
                rega_d = {1'b0, rega_q[WIDTH-1:1]};
                regb_d = {1'b0, regb_q[WIDTH-1:1]};
                br_d   = br_next;
                cnt_d  = cnt_q + CW'(1);
                if (last_cycle) begin
                    // The final bit is folded in directly so the visible result
                    // changes on the same edge that enters DONE.
                    diff_d   = {bit_d, res_q[WIDTH-1:1]};
                    borrow_d = br_next;
                    cnt_d    = '0;
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            rega_q   <= '0;
            regb_q   <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            br_q     <= 1'b0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rega_q   <= rega_d;
            regb_q   <= regb_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            br_q     <= br_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy   = (state_q == SHIFT);
    assign done   = (state_q == DONE);
    assign diff   = diff_q;
    assign borrow = borrow_q;

`ifdef SUB_OVERFLOW_EN
    // Operand sign bits are kept separately because the operand shift
    // registers have lost them by the time the result completes.
    logic amsb_q, amsb_d;
    logic bmsb_q, bmsb_d;
    logic ovf_q, ovf_d;

    always_comb begin
        amsb_d = amsb_q;
        bmsb_d = bmsb_q;
        ovf_d  = ovf_q;
        if (accept) begin
            amsb_d = a[WIDTH-1];
            bmsb_d = b[WIDTH-1];
        end
        if (last_cycle) begin
            // bit_d is the result MSB on the completing cycle.
            ovf_d = (amsb_q != bmsb_q) && (bit_d != amsb_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            amsb_q <= 1'b0;
            bmsb_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            amsb_q <= amsb_d;
            bmsb_q <= bmsb_d;
            ovf_q  <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule
